// File: rtl/lc3b_mem_bridge_pkg.sv
// Shared types for the LC-3b memory bridge: CPU-side word/mask types,
// the external byte type and the bridge state encoding.
package lc3b_mem_bridge_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic [7:0]  lc3b_byte;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } lc3b_bridge_state;

endpackage

// File: rtl/lc3b_mem_bridge_if.sv
// External 8-bit memory bus with a valid/ready handshake.
// master = bridge (drives req/we/addr/wdata), slave = memory (drives rdata/ack).
interface lc3b_mem_bridge_if;
  import lc3b_mem_bridge_pkg::*;

  logic     req;
  logic     we;
  lc3b_word addr;
  lc3b_byte wdata;
  lc3b_byte rdata;
  logic     ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/lc3b_mem_bridge.sv
// Splits 16-bit LC-3b memory requests into byte transfers on an 8-bit
// valid/ready bus, returns the read word with a one-cycle mem_resp, and
// aborts any byte transfer that waits too long so the CPU cannot hang.
module lc3b_mem_bridge
  import lc3b_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255  // max wait cycles per byte transfer; 0 = wait forever
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  lc3b_word                  mem_address,
  input  lc3b_word                  mem_wdata,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  lc3b_mem_wmask             mem_byte_enable,
  output lc3b_word                  mem_rdata,
  output logic                      mem_resp,
  output logic                      mem_err,
  lc3b_mem_bridge_if.master         ext
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lc3b_bridge_state state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_req_q, ext_req_d;
  logic             ext_we_q, ext_we_d;
  lc3b_word         ext_addr_q, ext_addr_d;
  lc3b_byte         ext_wdata_q, ext_wdata_d;
  lc3b_byte         wdata_hi_q, wdata_hi_d;   // high write byte, needed in HI
  logic             hi_en_q, hi_en_d;         // a HI transfer follows LO
  lc3b_byte         rbuf_lo_q, rbuf_lo_d;     // low read byte until the word completes
  lc3b_word         mem_rdata_q, mem_rdata_d;
  logic             mem_resp_q, mem_resp_d;
  logic             mem_err_q, mem_err_d;

  logic hs;
  logic timed_out;
  logic finish;

  // The word is always byte-pair aligned, so address bit 0 is dropped.
  logic addr_bit0_unused;
  assign addr_bit0_unused = mem_address[0];

  // Next-state and registered-output computation for the byte sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    wdata_hi_d  = wdata_hi_q;
    hi_en_d     = hi_en_q;
    rbuf_lo_d   = rbuf_lo_q;
    mem_rdata_d = mem_rdata_q;
    mem_resp_d  = 1'b0;
    mem_err_d   = 1'b0;
    finish      = 1'b0;

    hs        = ext_req_q & ext.ack;
    // Abort on the cycle whose un-acked wait would bring the count to TIMEOUT.
    timed_out = (TIMEOUT != 0) && ((int'(cnt_q) + 1) == TIMEOUT);

    unique case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          // Write wins when both are requested; reads always move both bytes.
          ext_we_d   = mem_write;
          wdata_hi_d = mem_wdata[15:8];
          cnt_d      = '0;
          if (!mem_write || mem_byte_enable[0]) begin
            state_d     = LO;
            ext_req_d   = 1'b1;
            ext_addr_d  = {mem_address[15:1], 1'b0};
            ext_wdata_d = mem_wdata[7:0];
            hi_en_d     = !mem_write || mem_byte_enable[1];
          end else if (mem_byte_enable[1]) begin
            state_d     = HI;
            ext_req_d   = 1'b1;
            ext_addr_d  = {mem_address[15:1], 1'b1};
            ext_wdata_d = mem_wdata[15:8];
            hi_en_d     = 1'b0;
          end else begin
            // Empty write mask: acknowledge without touching the bus.
            finish = 1'b1;
          end
        end
      end

      LO, HI: begin
        if (hs) begin
          cnt_d = '0;
          if (state_q == LO) begin
            if (!ext_we_q) rbuf_lo_d = ext.rdata;
            if (hi_en_q) begin
              // ext_req stays high; only address and data advance.
              state_d     = HI;
              ext_addr_d  = {ext_addr_q[15:1], 1'b1};
              ext_wdata_d = wdata_hi_q;
            end else begin
              finish = 1'b1;
            end
          end else begin
            if (!ext_we_q) mem_rdata_d = {ext.rdata, rbuf_lo_q};
            finish = 1'b1;
          end
        end else if (timed_out) begin
          cnt_d     = '0;
          finish    = 1'b1;
          mem_err_d = 1'b1;
          if (!ext_we_q) mem_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        // Any request still held here is only seen again from IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      state_d    = RESP;
      ext_req_d  = 1'b0;
      ext_we_d   = 1'b0;
      mem_resp_d = 1'b1;
    end
  end

  // State and output registers; reset drops the bus request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      wdata_hi_q  <= '0;
      hi_en_q     <= 1'b0;
      rbuf_lo_q   <= '0;
      mem_rdata_q <= '0;
      mem_resp_q  <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      wdata_hi_q  <= wdata_hi_d;
      hi_en_q     <= hi_en_d;
      rbuf_lo_q   <= rbuf_lo_d;
      mem_rdata_q <= mem_rdata_d;
      mem_resp_q  <= mem_resp_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign ext.req   = ext_req_q;
  assign ext.we    = ext_we_q;
  assign ext.addr  = ext_addr_q;
  assign ext.wdata = ext_wdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_resp  = mem_resp_q;
  assign mem_err   = mem_err_q;

endmodule

// File: doc/lc3b_mem_bridge.md
Name: lc3b_mem_bridge

Overview:
- Sits directly downstream of the LC-3b multicycle control/datapath memory port.
- Accepts the 16-bit mem_read/mem_write/mem_byte_enable request from the CPU and performs it as a sequence of byte transfers on an 8-bit external memory bus with a valid/ready handshake.
- Returns the read word and a single-cycle mem_resp pulse to the CPU.
- Has a bounded-wait timeout so the control FSM can never hang in a memory wait state.

Parameters:
- TIMEOUT, 255: maximum wait cycles per byte transfer before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_address  in  16  CPU byte address; bit 0 is ignored (word-aligned).
- mem_wdata  in  16  CPU write data.
- mem_read  in  1  CPU read request; level, held until mem_resp.
- mem_write  in  1  CPU write request; level, held until mem_resp.
- mem_byte_enable  in  2  lane mask: bit 0 = low byte, bit 1 = high byte.
- mem_rdata  out  16  read data, registered.
- mem_resp  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle pulse coincident with mem_resp when the transaction timed out.
- ext_req  out  1  external byte-transfer valid.
- ext_we  out  1  1 = write, 0 = read; valid while ext_req is high.
- ext_addr  out  16  external byte address.
- ext_wdata  out  8  external write byte.
- ext_rdata  in  8  external read byte; sampled on handshake.
- ext_ack  in  1  external ready; a transfer completes on a rising edge where ext_req and ext_ack are both high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - ext_req, ext_we, mem_resp and mem_err are 0.
  - ext_addr, ext_wdata and mem_rdata are 0.
  - Timeout counter is 0.
- States: IDLE, LO, HI, RESP.
- IDLE:
  - On mem_read or mem_write, latch the address, wdata, mask and direction.
  - If both are high, treat as a write.
  - Read: always transfer both bytes; the mask is ignored. Next state is LO.
  - Write: next state is LO if mask bit 0 is set, else HI if mask bit 1 is set, else RESP (mask 00 generates no external traffic).
- LO:
  - ext_req=1, ext_addr={addr[15:1],1'b0}, ext_wdata=wdata[7:0].
  - On handshake: read stores ext_rdata into the low byte of the read buffer.
  - Next state on handshake is HI if (read or mask bit 1), else RESP.
- HI:
  - ext_req=1, ext_addr={addr[15:1],1'b1}, ext_wdata=wdata[15:8].
  - On handshake: read stores the high byte; next state is RESP.
- Bus hold and timing rules:
  - ext_req stays high between LO and HI; the address and data change only after a handshake.
  - ext_* outputs are registered and stable while ext_req is high and ext_ack is low.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - For reads, mem_rdata is updated on entry to RESP and then holds until the next read completes. Writes never change mem_rdata.
  - ext_req=0.
  - Next state is always IDLE; a request still asserted during RESP is not accepted.
- Latency: with zero-wait ext_ack, a word read asserts mem_resp in the 4th cycle after mem_read is first sampled (IDLE, LO, HI, RESP). Each ack wait cycle adds 1 cycle.
- Timeout:
  - The counter clears on every handshake and on entry to LO or HI, and increments each LO/HI cycle without ack.
  - When the count reaches TIMEOUT: drop ext_req, go to RESP with mem_err=1.
  - On a read timeout, mem_rdata is 0x0000.
  - With TIMEOUT=0 the bridge waits indefinitely.
- Reset mid-transaction: ext_req drops immediately (asynchronous), no mem_resp is issued, and the CPU request is re-sampled from IDLE after reset.

Decomposition:
- lc3b_types gains:
  - lc3b_byte (logic [7:0]);
  - lc3b_bridge_state enum {IDLE, LO, HI, RESP}.
- The existing lc3b_word and lc3b_mem_wmask types are reused for the CPU-side ports.
- Single module; no sub-module. The timeout counter is inline, width $clog2(TIMEOUT+1), minimum 1.

Test Plan:
- Read at 0x3001, ext returns 0x34 (addr 0x3000) then 0x12 (addr 0x3001), ack always high -> mem_rdata=0x1234, mem_resp in cycle 4, mem_err=0.
- Read at 0x0040, ack low 3 cycles on HI byte -> ext_addr holds 0x0041 with ext_req high through the stall, mem_resp in cycle 7, one pulse only.
- Write 0xBEEF to 0x0100 with mask 01 -> a single ext write at 0x0100 with data 0xEF, no HI transfer, mem_resp in cycle 3.
- Write 0xBEEF with mask 10 -> a single write at 0x0101 with data 0xBE. Write with mask 00 -> no ext_req, mem_resp in cycle 2.
- TIMEOUT=4, read with ack never asserted -> ext_req drops after 4 LO cycles, mem_resp and mem_err pulse together, mem_rdata=0x0000.
- rst_n pulsed low during HI stall -> ext_req=0 asynchronously, state IDLE, no mem_resp; the held mem_read restarts a full LO/HI sequence after release.
